// File: rtl/paddle_input_pkg.sv
// Shared types and widths for the paddle input conditioner.
package paddle_input_pkg;

  localparam int WHEEL_W = 12;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  function automatic int sum_width(input int log2_avg);
    return WHEEL_W + log2_avg;
  endfunction

endpackage

// File: rtl/paddle_input_conditioner_key_debounce.sv
// Two-flop synchroniser plus tick-driven debounce FSM for one active-low key.
module key_debounce
  import paddle_input_pkg::*;
#(
  parameter int DEB_CNT = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic keyN_raw,
  output logic pressed
);

  localparam int CW = $clog2(DEB_CNT + 1);

  logic [1:0]    sync;
  logic          sample;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  // Synchroniser resets to "released" so a held key is seen only after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], keyN_raw};
  end

  assign sample = ~sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RELEASED;
      cnt     <= '0;
      pressed <= 1'b0;
    end else if (tick) begin
      case (state)
        RELEASED: if (sample) begin
          if (DEB_CNT == 1) begin
            state   <= PRESSED;
            pressed <= 1'b1;
          end else begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: if (sample) begin
          if (cnt == CW'(DEB_CNT - 1)) begin
            state   <= PRESSED;
            cnt     <= '0;
            pressed <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          state <= RELEASED;
          cnt   <= '0;
        end
        PRESSED: if (!sample) begin
          if (DEB_CNT == 1) begin
            state   <= RELEASED;
            pressed <= 1'b0;
          end else begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
        end
        RELEASE_WAIT: if (!sample) begin
          if (cnt == CW'(DEB_CNT - 1)) begin
            state   <= RELEASED;
            cnt     <= '0;
            pressed <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          state <= PRESSED;
          cnt   <= '0;
        end
        default: begin
          state   <= RELEASED;
          cnt     <= '0;
          pressed <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/paddle_input_conditioner.sv
// Wheel averaging/hysteresis and key debouncing for the paddle motion stage.
// Optional KEY_MUTEX_EN: suppresses up/down while both keys are held.
module paddle_input_conditioner
  import paddle_input_pkg::*;
#(
  parameter int SAMPLE_DIV = 50_000,
  parameter int LOG2_AVG   = 3,
  parameter int DEB_CNT    = 20,
  parameter int HYST       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WHEEL_W-1:0] wheel_raw,
  input  logic               upN_raw,
  input  logic               downN_raw,
  output logic [WHEEL_W-1:0] wheel,
  output logic               up,
  output logic               down,
  output logic               tick
);

  localparam int SW    = sum_width(LOG2_AVG);
  localparam int DEPTH = 1 << LOG2_AVG;
  localparam int PW    = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0]              div_cnt;
  logic [DEPTH-1:0][WHEEL_W-1:0] avg_buf;
  logic [PW-1:0]                 ptr;
  logic [SW-1:0]                 sum;
  logic                          sum_vld;
  logic [WHEEL_W-1:0]            avg;
  logic [WHEEL_W-1:0]            diff;
  logic                          up_p;
  logic                          down_p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == CNT_W'(SAMPLE_DIV - 1));
      div_cnt <= (div_cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + CNT_W'(1);
    end
  end

  // Running sum always equals the sum of the buffer, so it cannot overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_buf <= '0;
      ptr     <= '0;
      sum     <= '0;
      sum_vld <= 1'b0;
    end else begin
      sum_vld <= tick;
      if (tick) begin
        avg_buf[ptr] <= wheel_raw;
        sum          <= sum + SW'(wheel_raw) - SW'(avg_buf[ptr]);
        ptr          <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
      end
    end
  end

  assign avg  = WHEEL_W'(sum >> LOG2_AVG);
  assign diff = (avg > wheel) ? (avg - wheel) : (wheel - avg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   wheel <= '0;
    else if (sum_vld && diff > WHEEL_W'(HYST))   wheel <= avg;
  end

  key_debounce #(.DEB_CNT(DEB_CNT)) u_up_deb (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .keyN_raw (upN_raw),
    .pressed  (up_p)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_down_deb (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .keyN_raw (downN_raw),
    .pressed  (down_p)
  );

`ifdef KEY_MUTEX_EN
  assign up   = up_p & ~down_p;
  assign down = down_p & ~up_p;
`else
  assign up   = up_p;
  assign down = down_p;
`endif

endmodule

// File: doc/paddle_input_conditioner.md
Name: paddle_input_conditioner

Overview:
- Conditions raw player inputs before they reach the paddle-motion stage.
- Averages and hysteresis-filters the 12-bit ADC wheel sample.
- Synchronises and debounces the two active-low push-keys.
- Presents a clean wheel value and level-type up/down signals to the downstream position-update block.

Parameters:
- SAMPLE_DIV, 50_000, clk cycles per sample tick (1 kHz at 50 MHz); must be ≥ 2.
- LOG2_AVG, 3, log2 of moving-average window depth (window = 8 samples).
- DEB_CNT, 20, consecutive stable ticks required to accept a key level change; must be ≥ 1.
- HYST, 4, wheel output deadband in LSBs.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wheel_raw  in  12  unfiltered ADC wheel sample, may change any cycle
- upN_raw  in  1  raw up key, active-low, asynchronous
- downN_raw  in  1  raw down key, active-low, asynchronous
- wheel  out  12  filtered wheel value
- up  out  1  debounced up, active-high level
- down  out  1  debounced down, active-high level
- tick  out  1  one-cycle sample strobe

Behaviour:
- Reset (async, active-high) clears all state: wheel=0, up=0, down=0, tick=0, tick counter=0, average buffer and sum=0, debouncers in RELEASED with count 0, synchroniser flops=1 (keys released). Reset mid-operation aborts any pending average or debounce; no partial state survives.
- Tick generator:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is registered and high for exactly one cycle, in the cycle after the counter reaches SAMPLE_DIV-1.
- Key sync: each key uses a 2-flop synchroniser. The inverted output (pressed=1) feeds its debouncer.
- Wheel averaging:
  - Circular buffer of 2^LOG2_AVG 12-bit entries plus a write pointer.
  - On the edge where tick=1: buffer[ptr] <= wheel_raw; sum <= sum + wheel_raw − buffer[ptr]; ptr increments and wraps.
  - sum is 12+LOG2_AVG bits unsigned and never overflows.
  - avg = sum >> LOG2_AVG (floor).
  - After reset the buffer is zero-filled, so avg ramps up over the first 2^LOG2_AVG ticks.
- Hysteresis:
  - Evaluated on the edge after the sum update.
  - If |avg − wheel| > HYST, then wheel <= avg; otherwise wheel holds.
  - A difference of exactly HYST does not update. HYST=0 means any change updates.
  - wheel therefore changes at most once per tick, 2 clk edges after the tick-cycle edge.
- Debouncer FSM, one per key, evaluated only on tick; cnt is sized for DEB_CNT:
  - RELEASED: sample=1 → PRESS_WAIT with cnt=1. If DEB_CNT=1, go directly to PRESSED instead.
  - PRESS_WAIT: sample=1 → cnt+1; when cnt reaches DEB_CNT → PRESSED. sample=0 → RELEASED, cnt=0.
  - PRESSED: sample=0 → RELEASE_WAIT with cnt=1 (or RELEASED if DEB_CNT=1).
  - RELEASE_WAIT: sample=0 → cnt+1; when cnt reaches DEB_CNT → RELEASED. sample=1 → PRESSED, cnt=0.
  - Key output = 1 in PRESSED or RELEASE_WAIT, registered. It asserts on the edge of the DEB_CNT-th consecutive pressed tick.
  - Glitches shorter than DEB_CNT ticks never reach up/down.
- Simultaneous keys: both debounced independently. Without the optional feature, both outputs may be 1 together; the downstream stage resolves priority.

Optional Feature:
- Macro KEY_MUTEX_EN.
- When defined: if both debouncers are in pressed-level states, up and down are both forced to 0. Each output reappears as soon as the other key's debounced level drops. Debouncer FSMs are unaffected.
- When undefined: up and down reflect their debouncers directly.

Decomposition:
- Package paddle_input_pkg:
  - typedef enum deb_state_t {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT}
  - WHEEL_W=12 constant
  - function sum_width(log2_avg) = WHEEL_W+log2_avg
- One sub-module: key_debounce (sync + FSM; params DEB_CNT; ports clk, reset, tick, keyN_raw, pressed), instantiated twice.
- Tick generator and averager stay in the top.

Test Plan (SAMPLE_DIV=4, LOG2_AVG=2, DEB_CNT=3, HYST=4 unless stated):
1. Reset held 10 cycles with toggling inputs → wheel=0, up=0, down=0, tick=0 throughout. After release, tick first pulses on cycle 4, then every 4 cycles.
2. wheel_raw=400 constant from reset → wheel takes values 100, 200, 300, 400 on successive ticks, each 2 edges after tick, then holds.
3. Settled at 403 (wheel=400, diff 3, no update); wheel_raw→410 → tick1 avg=404 (diff 4, hold 400); tick2 avg=406 → wheel=406.
4. upN_raw low for 2 ticks then high → up stays 0. Low for 3 ticks → up=1 after 3rd tick. High for 2 ticks then low → up stays 1. High for 3 ticks → up=0.
5. Both keys low ≥3 ticks → up=1, down=1 without KEY_MUTEX_EN; up=0, down=0 with it. Release downN → up=1 after 3 ticks (mutex build).
6. reset pulsed while up debouncer is in PRESS_WAIT (cnt=2) and buffer half-filled → immediate all-zero outputs. Key still held → up asserts only after 3 full ticks post-reset; wheel ramps again from 0.
